// File: rtl/mem_stim_gen.sv
// Write-stream stimulus engine: COUNT / BYTE_COUNT / RANDOM streams over a timed run window,
// plus per-channel saturating error-edge counters. Optional sync output: define MEM_STIM_SYNC_EN.
module mem_stim_gen #(
    parameter int          NUM_CH    = 2,
    parameter int          DATA_W    = 32,
    parameter int          CYC_W     = 16,
    parameter int          ERRC_W    = 8,
    parameter int          ACT_W     = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 mode,
    input  logic [CYC_W-1:0]           run_cycles,
    input  logic [ACT_W-1:0]           activity,
    input  logic [NUM_CH-1:0]          err_detected,
    output logic [NUM_CH-1:0]          wr,
    output logic [NUM_CH*DATA_W-1:0]   data,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_CH*ERRC_W-1:0]   err_cnt,
    output logic                       err_any
`ifdef MEM_STIM_SYNC_EN
    ,
    output logic                       sync
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_BYTE   = 2'd1;
    localparam logic [1:0] MODE_RANDOM = 2'd2;

    state_t              state_r;
    logic [1:0]          mode_r;
    logic [CYC_W-1:0]    run_cycles_r;
    logic [CYC_W-1:0]    elapsed_r;
    logic [31:0]         lfsr_r     [NUM_CH];
    logic [31:0]         lfsr_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]   err_dly_r;
    logic [NUM_CH-1:0]   err_edge_s;
    logic [ERRC_W-1:0]   cnt_nxt_s  [NUM_CH];
    logic                go_s;
    logic                finish_s;
    logic                first_s;
    logic                step_s;
    logic                any_nxt_s;
    logic [1:0]          step_mode_s;

    // Galois form of x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_fill(input logic [31:0] v);
        logic [DATA_W-1:0] res;
        for (int b = 0; b < DATA_W; b++) begin
            res[b] = v[5'(b % 32)];
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] byte_fill(input logic [7:0] v);
        logic [DATA_W-1:0] res;
        for (int b = 0; b < DATA_W; b++) begin
            res[b] = v[3'(b % 8)];
        end
        return res;
    endfunction

    // Transition decode; abort overrides any start.
    always_comb begin
        go_s     = 1'b0;
        finish_s = 1'b0;
        if (abort) begin
            go_s = 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: go_s     = start;
                RUN:        finish_s = (elapsed_r == run_cycles_r - CYC_W'(1));
                default:    go_s     = 1'b0;
            endcase
        end
        first_s     = go_s && (run_cycles != {CYC_W{1'b0}});
        step_s      = first_s || ((state_r == RUN) && !abort && !finish_s);
        step_mode_s = go_s ? mode : mode_r;
        for (int i = 0; i < NUM_CH; i++) begin
            lfsr_nxt_s[i] = lfsr_step(lfsr_r[i]);
        end
    end

    // Run-window state machine with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            mode_r       <= 2'd0;
            run_cycles_r <= {CYC_W{1'b0}};
            elapsed_r    <= {CYC_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state_r <= IDLE;
                busy    <= 1'b0;
            end else if (go_s) begin
                mode_r       <= mode;
                run_cycles_r <= run_cycles;
                elapsed_r    <= {CYC_W{1'b0}};
                if (first_s) begin
                    state_r <= RUN;
                    busy    <= 1'b1;
                end else begin
                    state_r <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
            end else if (finish_s) begin
                state_r <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
            end else if (state_r == RUN) begin
                elapsed_r <= elapsed_r + CYC_W'(1);
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Write streams: wr is only driven high on edges that land in RUN; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr   <= {NUM_CH{1'b0}};
            data <= {(NUM_CH*DATA_W){1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                lfsr_r[i] <= LFSR_SEED ^ 32'(i + 1);
            end
        end else if (step_s) begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (step_mode_s)
                    MODE_COUNT: begin
                        wr[i] <= 1'b1;
                        data[i*DATA_W +: DATA_W] <= first_s ? DATA_W'(1)
                                                            : data[i*DATA_W +: DATA_W] + DATA_W'(1);
                    end
                    MODE_BYTE: begin
                        wr[i] <= 1'b1;
                        data[i*DATA_W +: DATA_W] <= byte_fill(first_s ? 8'h00
                                                                      : data[i*DATA_W +: 8] + 8'h01);
                    end
                    MODE_RANDOM: begin
                        lfsr_r[i] <= lfsr_nxt_s[i];
                        if (lfsr_nxt_s[i][ACT_W-1:0] <= activity) begin
                            wr[i]                    <= lfsr_nxt_s[i][31];
                            data[i*DATA_W +: DATA_W] <= lfsr_fill(lfsr_nxt_s[i]);
                        end else begin
                            wr[i] <= wr[i];
                        end
                    end
                    default: wr[i] <= 1'b0;
                endcase
            end
        end else begin
            wr <= {NUM_CH{1'b0}};
        end
    end

    // Next error counts: an edge coinciding with an accepted start counts as the first.
    always_comb begin
        err_edge_s = err_detected & ~err_dly_r;
        any_nxt_s  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (go_s) begin
                cnt_nxt_s[i] = err_edge_s[i] ? ERRC_W'(1) : {ERRC_W{1'b0}};
            end else if (err_edge_s[i] && (err_cnt[i*ERRC_W +: ERRC_W] != {ERRC_W{1'b1}})) begin
                cnt_nxt_s[i] = err_cnt[i*ERRC_W +: ERRC_W] + ERRC_W'(1);
            end else begin
                cnt_nxt_s[i] = err_cnt[i*ERRC_W +: ERRC_W];
            end
            any_nxt_s = any_nxt_s | (cnt_nxt_s[i] != {ERRC_W{1'b0}});
        end
    end

    // Error-edge counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_dly_r <= {NUM_CH{1'b0}};
            err_cnt   <= {(NUM_CH*ERRC_W){1'b0}};
            err_any   <= 1'b0;
        end else begin
            err_dly_r <= err_detected;
            for (int i = 0; i < NUM_CH; i++) begin
                err_cnt[i*ERRC_W +: ERRC_W] <= cnt_nxt_s[i];
            end
            err_any <= any_nxt_s;
        end
    end

`ifdef MEM_STIM_SYNC_EN
    localparam int SW = CYC_W + 4;
    logic [SW-1:0] elapsed_scaled_s;
    logic [SW-1:0] window_scaled_s;

    // Compare against the elapsed value being loaded so sync rises with that count.
    always_comb begin
        elapsed_scaled_s = SW'(11) * (SW'(elapsed_r) + SW'(1));
        window_scaled_s  = SW'(10) * SW'(run_cycles_r);
    end

    // Sticky late-window flag, cleared by start or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 1'b0;
        end else if (abort || go_s) begin
            sync <= 1'b0;
        end else if (step_s && (elapsed_scaled_s > window_scaled_s)) begin
            sync <= 1'b1;
        end else begin
            sync <= sync;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stim_gen.sv
// Self-checking bench for mem_stim_gen: randomized runs against a behavioural stream/error model.
module tb_mem_stim_gen;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int CYC_W  = 16;
    localparam int ERRC_W = 8;
    localparam int ACT_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [CYC_W-1:0] run_cycles = 16'd0;
    logic [ACT_W-1:0] activity = 4'd0;
    logic [NUM_CH-1:0] err_detected = 2'b00;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH*DATA_W-1:0] data;
    logic busy, done;
    logic [NUM_CH*ERRC_W-1:0] err_cnt;
    logic err_any;
`ifdef MEM_STIM_SYNC_EN
    logic sync;
`endif

    int errors = 0;
    int checks = 0;
    int wr_changes;
    logic [31:0] m_lfsr [NUM_CH];
    logic [DATA_W-1:0] m_data [NUM_CH];
    logic [NUM_CH-1:0] m_wr;
    int m_cnt [NUM_CH];
    logic [NUM_CH-1:0] m_err_prev = 2'b00;
    logic [31:0] cur_q [$];
    logic [31:0] first_q [$];

    always #5 clk = ~clk;

    mem_stim_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .run_cycles(run_cycles), .activity(activity), .err_detected(err_detected),
        .wr(wr), .data(data), .busy(busy), .done(done), .err_cnt(err_cnt), .err_any(err_any)
`ifdef MEM_STIM_SYNC_EN
        , .sync(sync)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
        if (v[0]) return (v >> 1) ^ 32'h8020_0003;
        return v >> 1;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_lfsr[ch] = 32'hACE1_2468 ^ 32'(ch + 1);
            m_data[ch] = 32'd0;
            m_cnt[ch]  = 0;
        end
        m_wr = 2'b00;
    endtask

    task automatic check_streams(input string tag);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check_eq($sformatf("%s wr%0d", tag, ch), 64'(wr[ch]), 64'(m_wr[ch]));
            check_eq($sformatf("%s data%0d", tag, ch), 64'(data[ch*DATA_W +: DATA_W]), 64'(m_data[ch]));
        end
    endtask

    // One complete run: start pulse, run window, DONE cycle; inputs scrambled while running.
    task automatic do_run(input logic [1:0] md, input int rc, input logic [ACT_W-1:0] act);
        logic prev;
        logic [7:0] b8;
        cur_q.delete();
        wr_changes = 0;
        prev = wr[0];
        mode = md; run_cycles = CYC_W'(rc); activity = act; start = 1'b1;
        for (int k = 0; k < rc; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                case (md)
                    2'd0: begin m_wr[ch] = 1'b1; m_data[ch] = DATA_W'(k + 1); end
                    2'd1: begin b8 = 8'(k); m_wr[ch] = 1'b1; m_data[ch] = {b8, b8, b8, b8}; end
                    2'd2: begin
                        m_lfsr[ch] = lfsr_adv(m_lfsr[ch]);
                        if (m_lfsr[ch][ACT_W-1:0] <= act) begin
                            m_wr[ch] = m_lfsr[ch][31];
                            m_data[ch] = m_lfsr[ch];
                        end
                    end
                    default: m_wr[ch] = 1'b0;
                endcase
            end
            tick();
            start = 1'($urandom_range(0, 1));
            mode = 2'($urandom);
            run_cycles = CYC_W'($urandom);
            check_eq($sformatf("m%0d k%0d busy", md, k), 64'(busy), 64'd1);
            check_eq($sformatf("m%0d k%0d done", md, k), 64'(done), 64'd0);
            check_streams($sformatf("m%0d k%0d", md, k));
`ifdef MEM_STIM_SYNC_EN
            check_eq($sformatf("m%0d k%0d sync", md, k), 64'(sync), 64'(11 * k > 10 * rc));
`endif
            if (wr[0] != prev) wr_changes++;
            prev = wr[0];
            cur_q.push_back(data[31:0]);
        end
        if (rc != 0) start = 1'b0;
        m_wr = 2'b00;
        tick();
        start = 1'b0;
        check_eq($sformatf("m%0d end busy", md), 64'(busy), 64'd0);
        check_eq($sformatf("m%0d end done", md), 64'(done), 64'd1);
        check_streams($sformatf("m%0d end", md));
`ifdef MEM_STIM_SYNC_EN
        check_eq($sformatf("m%0d end sync", md), 64'(sync), 64'((rc > 0) && (11 * (rc - 1) > 10 * rc)));
`endif
        tick();
        check_eq($sformatf("m%0d post done", md), 64'(done), 64'd0);
    endtask

    task automatic err_step(input logic [NUM_CH-1:0] e, input logic st);
        logic any;
        err_detected = e; start = st; run_cycles = 16'd0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (st) m_cnt[ch] = (e[ch] && !m_err_prev[ch]) ? 1 : 0;
            else if (e[ch] && !m_err_prev[ch] && m_cnt[ch] < 255) m_cnt[ch]++;
        end
        m_err_prev = e;
        tick();
        start = 1'b0;
        any = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check_eq($sformatf("errcnt%0d", ch), 64'(err_cnt[ch*ERRC_W +: ERRC_W]), 64'(m_cnt[ch]));
            any = any | (m_cnt[ch] != 0);
        end
        check_eq("err_any", 64'(err_any), 64'(any));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " wr"}, 64'(wr), 64'd0);
        check_eq({tag, " data"}, 64'(data), 64'd0);
        check_eq({tag, " busy"}, 64'(busy), 64'd0);
        check_eq({tag, " done"}, 64'(done), 64'd0);
        check_eq({tag, " errcnt"}, 64'(err_cnt), 64'd0);
        check_eq({tag, " err_any"}, 64'(err_any), 64'd0);
    endtask

    initial begin
        logic saw_done;
        model_reset();
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        do_run(2'd2, 40, 4'hF);
        first_q = cur_q;
        do_run(2'd0, 5, 4'h0);
        do_run(2'd1, 258, 4'h0);
        do_run(2'd0, 0, 4'h0);
        do_run(2'd3, 7, 4'h0);
        do_run(2'd2, 1000, 4'h0);
        check_eq("rate_low", 64'(wr_changes < 150), 64'd1);
        do_run(2'd2, 1000, 4'hF);
        check_eq("rate_high", 64'(wr_changes > 300), 64'd1);
        do_run(2'd0, 100, 4'h0);
        for (int r = 0; r < 6; r++) begin
            do_run(2'($urandom), $urandom_range(0, 60), 4'($urandom));
        end

        // abort during RUN cycle 3 of 10
        mode = 2'd0; run_cycles = 16'd10; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check_eq("abort pre data", 64'(data[31:0]), 64'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort busy", 64'(busy), 64'd0);
        check_eq("abort wr", 64'(wr), 64'd0);
        check_eq("abort done", 64'(done), 64'd0);
        check_eq("abort data", 64'(data), 64'h0000_0003_0000_0003);
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        check_eq("abort quiet", 64'(saw_done), 64'd0);
        start = 1'b1; abort = 1'b1; run_cycles = 16'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        check_eq("abort_beats_start busy", 64'(busy), 64'd0);
        tick();
        check_eq("abort_beats_start done", 64'(done), 64'd0);

        // error-edge counters
        err_step(2'b00, 1'b1);
        for (int p = 0; p < 3; p++) begin
            err_step(2'b10, 1'b0);
            err_step(2'b00, 1'b0);
        end
        for (int p = 0; p < 10; p++) err_step(2'b10, 1'b0);
        err_step(2'b00, 1'b0);
        for (int p = 0; p < 300; p++) begin
            err_step(2'b10, 1'b0);
            err_step(2'b00, 1'b0);
        end
        err_step(2'b10, 1'b0);
        err_step(2'b11, 1'b1);
        err_step(2'b00, 1'b1);
        for (int p = 0; p < 200; p++) begin
            err_step(2'($urandom), 1'($urandom_range(0, 9) == 0));
        end
        err_step(2'b01, 1'b0);

        // reset in the middle of a run, then reproduce the first RANDOM run
        mode = 2'd0; run_cycles = 16'd30; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        err_detected = 2'b00;
        m_err_prev = 2'b00;
        #1;
        check_all_zero("midrun reset");
        tick(); tick();
        rst_n = 1'b1;
        model_reset();
        tick();
        check_eq("post reset done", 64'(done), 64'd0);
        do_run(2'd2, 40, 4'hF);
        check_eq("repro size", 64'(cur_q.size()), 64'(first_q.size()));
        for (int k = 0; k < first_q.size() && k < cur_q.size(); k++) begin
            check_eq($sformatf("repro k%0d", k), 64'(cur_q[k]), 64'(first_q[k]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
